// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Desc     : Fixed-latency data memory responder with byte-lane writes.
//            Access counters are built only when DMEM_ACCESS_CNT_EN is defined.
// Revision : 1.0
// ============================================================================
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_byte_enable,
    output logic [31:0] mem_rdata,
    output logic        mem_resp,
    output logic        mem_error,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count
);
    localparam int         c_IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [3:0] c_BUSY_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [3:0]          r_cnt;
    logic [c_IDX_W-1:0]  r_idx;
    logic [31:0]         r_wdata;
    logic [3:0]          r_be;
    logic                r_rd;
    logic                r_wr;
    logic [31:0]         r_rdata;
    logic [31:0]         r_mem [DEPTH_WORDS];

    logic [c_IDX_W-1:0]  w_req_idx;
    logic [c_IDX_W-1:0]  w_ld_idx;
    logic                w_accept;
    logic                w_ld_rd;
    logic                w_legal_wr;
    logic                w_unused;

    assign w_req_idx  = mem_address[c_IDX_W+1:2];
    assign w_unused   = ^{mem_address[31:c_IDX_W+2], mem_address[1:0]};
    assign w_accept   = (r_state == S_IDLE) && (mem_read || mem_write);
    assign w_legal_wr = r_wr && !r_rd;

    // With LATENCY=1 the response is entered straight from IDLE, so the read
    // must be taken from the live request rather than the latched copy.
    assign w_ld_rd  = (r_state == S_IDLE) ? (mem_read && !mem_write) : (r_rd && !r_wr);
    assign w_ld_idx = (r_state == S_IDLE) ? w_req_idx : r_idx;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (mem_read || mem_write) begin
                    w_next = (LATENCY == 1) ? S_RESP : S_BUSY;
                end
            end
            S_BUSY: begin
                if (r_cnt == 4'd0) begin
                    w_next = S_RESP;
                end
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_idx   <= '0;
            r_wdata <= 32'd0;
            r_be    <= 4'd0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_rdata <= 32'd0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_idx   <= w_req_idx;
                r_wdata <= mem_wdata;
                r_be    <= mem_byte_enable;
                r_rd    <= mem_read;
                r_wr    <= mem_write;
                r_cnt   <= c_BUSY_LOAD;
            end else if ((r_state == S_BUSY) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if ((w_next == S_RESP) && w_ld_rd) begin
                r_rdata <= r_mem[w_ld_idx];
            end
        end
    end

    // Storage is deliberately outside the reset domain; an aborted write never
    // reaches RESP, so it cannot commit.
    always_ff @(posedge clk) begin
        if ((r_state == S_RESP) && w_legal_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (r_be[i]) begin
                    r_mem[r_idx][8*i +: 8] <= r_wdata[8*i +: 8];
                end
            end
        end
    end

    assign mem_rdata = r_rdata;
    assign mem_resp  = (r_state == S_RESP);
    assign mem_error = (r_state == S_RESP) && r_rd && r_wr;

`ifdef DMEM_ACCESS_CNT_EN
    logic [31:0] r_rd_count;
    logic [31:0] r_wr_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_count <= 32'd0;
            r_wr_count <= 32'd0;
        end else if (r_state == S_RESP) begin
            if (r_rd && !r_wr) begin
                r_rd_count <= r_rd_count + 32'd1;
            end
            if (w_legal_wr) begin
                r_wr_count <= r_wr_count + 32'd1;
            end
        end
    end

    assign rd_count = r_rd_count;
    assign wr_count = r_wr_count;
`else
    assign rd_count = 32'd0;
    assign wr_count = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Desc     : Directed self-checking bench for dmem_responder (LATENCY 2 and 1).
// Revision : 1.0
// ============================================================================
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd_i    [2];
    logic        wr_i    [2];
    logic [31:0] addr_i  [2];
    logic [31:0] wdata_i [2];
    logic [3:0]  be_i    [2];
    logic [31:0] rdata_o [2];
    logic        resp_o  [2];
    logic        err_o   [2];
    logic [31:0] rdc_o   [2];
    logic [31:0] wrc_o   [2];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .mem_read(rd_i[0]), .mem_write(wr_i[0]), .mem_address(addr_i[0]),
        .mem_wdata(wdata_i[0]), .mem_byte_enable(be_i[0]),
        .mem_rdata(rdata_o[0]), .mem_resp(resp_o[0]), .mem_error(err_o[0]),
        .rd_count(rdc_o[0]), .wr_count(wrc_o[0])
    );

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) u_dut_l1 (
        .clk(clk), .rst_n(rst_n),
        .mem_read(rd_i[1]), .mem_write(wr_i[1]), .mem_address(addr_i[1]),
        .mem_wdata(wdata_i[1]), .mem_byte_enable(be_i[1]),
        .mem_rdata(rdata_o[1]), .mem_resp(resp_o[1]), .mem_error(err_o[1]),
        .rd_count(rdc_o[1]), .wr_count(wrc_o[1])
    );

    function automatic logic [31:0] exp_cnt(input int n);
`ifdef DMEM_ACCESS_CNT_EN
        return 32'(n);
`else
        return 32'd0 & 32'(n);
`endif
    endfunction

    // Drives one request starting just after a negedge; returns the number of
    // cycles to mem_resp (0 on timeout) and whether resp was still high after.
    task automatic do_req(input int d, input logic r, input logic w,
                          input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                          output int lat, output logic err, output logic [31:0] rdata,
                          output logic resp_after);
        rd_i[d] = r; wr_i[d] = w; addr_i[d] = a; wdata_i[d] = wd; be_i[d] = be;
        lat = 0; err = 1'bx; rdata = 'x;
        @(posedge clk);
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (resp_o[d] === 1'b1) begin
                lat = n; err = err_o[d]; rdata = rdata_o[d];
                break;
            end
        end
        rd_i[d] = 1'b0; wr_i[d] = 1'b0;
        @(negedge clk);
        resp_after = resp_o[d];
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            rd_i[d] = 0; wr_i[d] = 0; addr_i[d] = 0; wdata_i[d] = 0; be_i[d] = 0;
        end
        repeat (3) @(negedge clk);
        n_cmp++; if (resp_o[0] !== 1'b0) begin n_bad++; $display("FAIL rst_resp: got %b expected 0", resp_o[0]); end
        n_cmp++; if (err_o[0] !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b expected 0", err_o[0]); end
        n_cmp++; if (rdata_o[0] !== 32'h0) begin n_bad++; $display("FAIL rst_rdata: got %h expected 0", rdata_o[0]); end
        n_cmp++; if (rdc_o[0] !== 32'h0) begin n_bad++; $display("FAIL rst_rd_count: got %h expected 0", rdc_o[0]); end
        n_cmp++; if (wrc_o[0] !== 32'h0) begin n_bad++; $display("FAIL rst_wr_count: got %h expected 0", wrc_o[0]); end
        rst_n = 1'b1;
    endtask

    task automatic test_write_read();
        int lat; logic err, ra; logic [31:0] rd;
        do_req(0, 0, 1, 32'h10, 32'hDEADBEEF, 4'hF, lat, err, rd, ra);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL wr_latency: got %0d expected 2", lat); end
        n_cmp++; if (ra !== 1'b0) begin n_bad++; $display("FAIL wr_single_pulse: got %b expected 0", ra); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL wr_err: got %b expected 0", err); end
        do_req(0, 1, 0, 32'h10, 32'h0, 4'h0, lat, err, rd, ra);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL rd_latency: got %0d expected 2", lat); end
        n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rd_data_10: got %h expected deadbeef", rd); end
    endtask

    task automatic test_byte_enable();
        int lat; logic err, ra; logic [31:0] rd;
        do_req(0, 0, 1, 32'h20, 32'h11223344, 4'hF, lat, err, rd, ra);
        do_req(0, 0, 1, 32'h20, 32'hAABBCCDD, 4'b0101, lat, err, rd, ra);
        n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL wr_keeps_rdata: got %h expected deadbeef", rd); end
        do_req(0, 1, 0, 32'h20, 32'h0, 4'h0, lat, err, rd, ra);
        n_cmp++; if (rd !== 32'h11BB33DD) begin n_bad++; $display("FAIL be_0101: got %h expected 11bb33dd", rd); end
        do_req(0, 0, 1, 32'h20, 32'hFFFFFFFF, 4'b0000, lat, err, rd, ra);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL be_0000_resp: got %0d expected 2", lat); end
        do_req(0, 1, 0, 32'h20, 32'h0, 4'h0, lat, err, rd, ra);
        n_cmp++; if (rd !== 32'h11BB33DD) begin n_bad++; $display("FAIL be_0000: got %h expected 11bb33dd", rd); end
    endtask

    task automatic test_illegal();
        int lat; logic err, ra; logic [31:0] rd;
        do_req(0, 1, 1, 32'h20, 32'h0, 4'hF, lat, err, rd, ra);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL ill_latency: got %0d expected 2", lat); end
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL ill_err: got %b expected 1", err); end
        n_cmp++; if (rd !== 32'h11BB33DD) begin n_bad++; $display("FAIL ill_rdata: got %h expected 11bb33dd", rd); end
        n_cmp++; if (rdc_o[0] !== exp_cnt(3)) begin n_bad++; $display("FAIL ill_rd_count: got %h expected %h", rdc_o[0], exp_cnt(3)); end
        n_cmp++; if (wrc_o[0] !== exp_cnt(4)) begin n_bad++; $display("FAIL ill_wr_count: got %h expected %h", wrc_o[0], exp_cnt(4)); end
        do_req(0, 1, 0, 32'h20, 32'h0, 4'h0, lat, err, rd, ra);
        n_cmp++; if (rd !== 32'h11BB33DD) begin n_bad++; $display("FAIL ill_storage: got %h expected 11bb33dd", rd); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL legal_err: got %b expected 0", err); end
    endtask

    task automatic test_wrap();
        int lat; logic err, ra; logic [31:0] rd;
        do_req(0, 0, 1, 32'h400, 32'h5A5A5A5A, 4'hF, lat, err, rd, ra);
        do_req(0, 1, 0, 32'h000, 32'h0, 4'h0, lat, err, rd, ra);
        n_cmp++; if (rd !== 32'h5A5A5A5A) begin n_bad++; $display("FAIL wrap: got %h expected 5a5a5a5a", rd); end
    endtask

    task automatic test_latency1();
        int lat; logic err, ra; logic [31:0] rd;
        do_req(1, 0, 1, 32'h8, 32'h12345678, 4'hF, lat, err, rd, ra);
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL l1_wr_latency: got %0d expected 1", lat); end
        n_cmp++; if (ra !== 1'b0) begin n_bad++; $display("FAIL l1_single_pulse: got %b expected 0", ra); end
        do_req(1, 1, 0, 32'h8, 32'h0, 4'h0, lat, err, rd, ra);
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL l1_rd_latency: got %0d expected 1", lat); end
        n_cmp++; if (rd !== 32'h12345678) begin n_bad++; $display("FAIL l1_rd_data: got %h expected 12345678", rd); end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        rd_i[0] = 1'b1; wr_i[0] = 1'b0; addr_i[0] = 32'h10; be_i[0] = 4'h0;
        repeat (6) begin
            @(negedge clk);
            if (resp_o[0] === 1'b1) pulses++;
        end
        rd_i[0] = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (pulses !== 2) begin n_bad++; $display("FAIL held_req_repeat: got %0d expected 2", pulses); end
    endtask

    task automatic test_reset_abort();
        int lat; logic err, ra; logic [31:0] rd; int pulses = 0;
        do_req(0, 0, 1, 32'h30, 32'hCAFEF00D, 4'hF, lat, err, rd, ra);
        do_req(0, 1, 0, 32'h10, 32'h0, 4'h0, lat, err, rd, ra);
        rd_i[0] = 1'b0; wr_i[0] = 1'b1; addr_i[0] = 32'h30; wdata_i[0] = 32'h0BADBEEF; be_i[0] = 4'hF;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (resp_o[0] !== 1'b0) begin n_bad++; $display("FAIL abort_resp: got %b expected 0", resp_o[0]); end
        n_cmp++; if (rdata_o[0] !== 32'h0) begin n_bad++; $display("FAIL abort_rdata: got %h expected 0", rdata_o[0]); end
        n_cmp++; if (rdc_o[0] !== 32'h0) begin n_bad++; $display("FAIL abort_rd_count: got %h expected 0", rdc_o[0]); end
        wr_i[0] = 1'b0;
        repeat (2) begin @(negedge clk); if (resp_o[0] !== 1'b0) pulses++; end
        rst_n = 1'b1;
        repeat (3) begin @(negedge clk); if (resp_o[0] !== 1'b0) pulses++; end
        n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL abort_no_resp: got %0d expected 0", pulses); end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        do_req(0, 1, 0, 32'h30, 32'h0, 4'h0, lat, err, rd, ra);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL first_edge_accept: got %0d expected 2", lat); end
        n_cmp++; if (rd !== 32'hCAFEF00D) begin n_bad++; $display("FAIL abort_storage: got %h expected cafef00d", rd); end
    endtask

    task automatic test_counters();
        int lat; logic err, ra; logic [31:0] rd;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        do_req(0, 1, 0, 32'h10, 32'h0, 4'h0, lat, err, rd, ra);
        do_req(0, 0, 1, 32'h40, 32'h01020304, 4'hF, lat, err, rd, ra);
        do_req(0, 1, 0, 32'h20, 32'h0, 4'h0, lat, err, rd, ra);
        do_req(0, 1, 1, 32'h40, 32'h0, 4'hF, lat, err, rd, ra);
        do_req(0, 0, 1, 32'h44, 32'h05060708, 4'h3, lat, err, rd, ra);
        do_req(0, 1, 0, 32'h40, 32'h0, 4'h0, lat, err, rd, ra);
        n_cmp++; if (rd !== 32'h01020304) begin n_bad++; $display("FAIL cnt_rd_data: got %h expected 01020304", rd); end
        n_cmp++; if (rdc_o[0] !== exp_cnt(3)) begin n_bad++; $display("FAIL rd_count: got %h expected %h", rdc_o[0], exp_cnt(3)); end
        n_cmp++; if (wrc_o[0] !== exp_cnt(2)) begin n_bad++; $display("FAIL wr_count: got %h expected %h", wrc_o[0], exp_cnt(2)); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write_read();
        test_byte_enable();
        test_illegal();
        test_wrap();
        test_latency1();
        test_back_to_back();
        test_reset_abort();
        test_counters();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
